multi_decade_counter: RTL

MULTI_DECADE_COUNTER -- requirements
Module: multi_decade_counter

---
 rtl/multi_decade_counter_pkg.sv | 20 ++
 rtl/mod_digit_cell.sv | 60 ++++++
 rtl/multi_decade_counter.sv | 104 ++++++++++
 3 files changed

// File: rtl/multi_decade_counter_pkg.sv
// Shared constants for the multi-decade counter.
//   DIGIT_W          : bits per packed digit on data_in / count
//   DIGITS_MIN/_MAX  : legal range of the DIGITS parameter
//   MOD_MIN/_MAX     : legal range of the per-digit modulus
//   params_ok()      : elaboration-time legality check for a configuration
package multi_decade_counter_pkg;

  localparam int DIGIT_W    = 4;
  localparam int DIGITS_MIN = 1;
  localparam int DIGITS_MAX = 8;
  localparam int MOD_MIN    = 2;
  localparam int MOD_MAX    = 16;

  function automatic bit params_ok(int digits, int modulus, int wrap);
    return (digits >= DIGITS_MIN) && (digits <= DIGITS_MAX) &&
           (modulus >= MOD_MIN) && (modulus <= MOD_MAX) &&
           ((wrap == 0) || (wrap == 1));
  endfunction

endpackage

// File: rtl/mod_digit_cell.sv
// One modulo-MOD digit of the cascaded counter.
// Ports:
//   clock_i, reset_i : clock and synchronous active-high reset
//   load_i           : parallel load strobe (higher priority than step_i)
//   load_digit_i     : value to load; values >= MOD are replaced by 0
//   step_i           : advance this digit by one in direction up_i
//   up_i             : 1 = increment, 0 = decrement
//   digit_o          : registered digit value (always < MOD)
//   at_max_o         : digit equals MOD-1
//   at_zero_o        : digit equals 0
//   load_bad_o       : load_digit_i is out of range (combinational)
module mod_digit_cell
  import multi_decade_counter_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [DIGIT_W-1:0] load_digit_i,
  input  logic               step_i,
  input  logic               up_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               at_max_o,
  output logic               at_zero_o,
  output logic               load_bad_o
);

  localparam logic [DIGIT_W-1:0] MAX_VAL = DIGIT_W'(MOD - 1);

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] digit_d;

  assign at_max_o   = (digit_q == MAX_VAL);
  assign at_zero_o  = (digit_q == '0);
  assign load_bad_o = (load_digit_i > MAX_VAL);
  assign digit_o    = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_bad_o ? '0 : load_digit_i;
    end else if (step_i) begin
      if (up_i) begin
        digit_d = at_max_o ? '0 : digit_q + DIGIT_W'(1);
      end else begin
        digit_d = at_zero_o ? MAX_VAL : digit_q - DIGIT_W'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/multi_decade_counter.sv
// Cascaded up/down counter of DIGITS modulo-MOD digits with parallel load.
// Parameters: DIGITS (1..8), MOD (2..16), WRAP (1 = wrap, 0 = saturate).
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   load         : parallel load strobe; illegal digits load as 0
//   data_in      : load value, digit k at [4k+3:4k]
//   counter_on   : count enable
//   counter_up   : direction, 1 = up, 0 = down
//   count        : registered counter value
//   TC           : combinational terminal count (0 while load=1)
//   overflow     : sticky flag, set by any step taken at terminal count,
//                  cleared by load or reset
//   load_err     : one-cycle flag, 1 after a load that replaced a digit
// Priority per cycle: reset > load > count > hold.
module multi_decade_counter
  import multi_decade_counter_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int MOD    = 10,
  parameter int WRAP   = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] data_in,
  input  logic                      counter_on,
  input  logic                      counter_up,
  output logic [DIGIT_W*DIGITS-1:0] count,
  output logic                      TC,
  output logic                      overflow,
  output logic                      load_err
);

  if (!params_ok(DIGITS, MOD, WRAP)) begin : g_bad_params
    $error("multi_decade_counter: illegal DIGITS/MOD/WRAP configuration");
  end

  localparam logic SATURATE = (WRAP == 0);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_zero;
  logic [DIGITS-1:0] load_bad;
  logic [DIGITS-1:0] step;
  // chain[k] = every digit below k is at its rollover value for the
  // current direction; chain[DIGITS] therefore means "whole counter terminal".
  logic [DIGITS:0]   chain;
  logic              count_step;
  logic              sat_hold;

  logic overflow_q, overflow_d;
  logic load_err_q, load_err_d;

  assign chain[0]   = 1'b1;
  assign count_step = counter_on & ~load;
  assign TC         = count_step & chain[DIGITS];
  // In saturate mode a terminal step freezes every digit.
  assign sat_hold   = TC & SATURATE;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign chain[k+1] = chain[k] & (counter_up ? at_max[k] : at_zero[k]);
    assign step[k]    = count_step & chain[k] & ~sat_hold;

    mod_digit_cell #(
      .MOD (MOD)
    ) u_cell (
      .clock_i      (clock),
      .reset_i      (reset),
      .load_i       (load),
      .load_digit_i (data_in[DIGIT_W*k +: DIGIT_W]),
      .step_i       (step[k]),
      .up_i         (counter_up),
      .digit_o      (count[DIGIT_W*k +: DIGIT_W]),
      .at_max_o     (at_max[k]),
      .at_zero_o    (at_zero[k]),
      .load_bad_o   (load_bad[k])
    );
  end

  always_comb begin
    overflow_d = overflow_q;
    load_err_d = 1'b0;
    if (load) begin
      // Load wins over a coincident terminal step, so overflow clears.
      overflow_d = 1'b0;
      load_err_d = |load_bad;
    end else if (TC) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      load_err_q <= load_err_d;
    end
  end

  assign overflow = overflow_q;
  assign load_err = load_err_q;

endmodule
